ps2_key_event_decoder: RTL and testbench

Parametrised PS/2 scan-code-set-2 event decoder. It sits between the PS/2 byte receiver and the consumer, for example a UI FSM or a display controller. It turns the raw byte stream into whole key events (make/break, extended flag, code), with selectable event filtering and typematic-repeat suppression. Events are buffered in an internal FIFO with overflow reporting.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/key_event_fifo.sv | 54 +++++
 rtl/ps2_key_event_decoder.sv | 140 ++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code-set-2 key event decoder:
// protocol bytes, filter modes, event width and decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  // Keyboard housekeeping bytes that never form part of a key event
  localparam logic [7:0] PS2_NUL    = 8'h00;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR    = 8'hFF;

  localparam int MODE_BRK  = 0;
  localparam int MODE_MAKE = 1;
  localparam int MODE_BOTH = 2;

  localparam int EVT_W = 10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;

  // Pause is E1 followed by seven more bytes that carry no extra information
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_NUL) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERR);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO. A pop and a push in the same cycle
// are both honoured even when full; the head reads as zero while empty.
module key_event_fifo #(
  parameter int B = 10,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 1 << W;

  logic [W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [B-1:0] mem_q [DEPTH];
  logic [B-1:0] mem_d [DEPTH];
  logic         rd_en, wr_en;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[W] != rptr_q[W]) && (wptr_q[W-1:0] == rptr_q[W-1:0]);
  assign rd_en  = rd && !empty;
  // When full, a write is only possible if the head leaves this cycle
  assign wr_en  = wr && (!full || rd_en);
  assign r_data = empty ? '0 : mem_q[rptr_q[W-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    if (wr_en) begin
      mem_d[wptr_q[W-1:0]] = w_data;
      wptr_d = wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 byte stream to key event decoder with mode filter, typematic
// repeat suppression and a buffered, overflow-reporting event queue.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int W_SIZE    = 2,
  parameter int MODE      = 2,
  parameter int NO_REPEAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  input  logic             rd_event,
  input  logic             clr_ovf,
  output logic [EVT_W-1:0] event_data,
  output logic             buf_empty,
  output logic             buf_full,
  output logic             overflow
);

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lm_valid_q, lm_valid_d;
  logic [8:0] lm_key_q, lm_key_d;
  logic       ovf_q, ovf_d;

  logic       evt_v, evt_ext, evt_brk;
  logic [7:0] evt_code;
  logic       rep_hit, mode_ok, evt_wr, drop;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    evt_v    = 1'b0;
    evt_ext  = 1'b0;
    evt_brk  = 1'b0;
    evt_code = rx_data;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_EXT)        state_d = ST_EXT;
          else if (rx_data == PS2_BRK)   state_d = ST_BRK;
          else if (rx_data == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            cnt_d   = PAUSE_SKIP;
          end else if (!is_discard(rx_data)) evt_v = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) state_d = ST_EXT_BRK;
          else if (rx_data != PS2_EXT) begin
            evt_v   = 1'b1;
            evt_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          evt_v   = 1'b1;
          evt_brk = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          evt_v   = 1'b1;
          evt_ext = 1'b1;
          evt_brk = 1'b1;
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            evt_v    = 1'b1;
            evt_ext  = 1'b1;
            evt_code = PS2_PAUSE;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Repeat tracking runs on every decoded event, independent of the mode filter
  always_comb begin
    lm_valid_d = lm_valid_q;
    lm_key_d   = lm_key_q;
    rep_hit    = 1'b0;
    if ((NO_REPEAT != 0) && evt_v) begin
      if (!evt_brk) begin
        if (lm_valid_q && (lm_key_q == {evt_ext, evt_code})) rep_hit = 1'b1;
        else begin
          lm_valid_d = 1'b1;
          lm_key_d   = {evt_ext, evt_code};
        end
      end else if (lm_key_q == {evt_ext, evt_code}) begin
        lm_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    mode_ok = (MODE == MODE_BOTH) ||
              ((MODE == MODE_MAKE) && !evt_brk) ||
              ((MODE == MODE_BRK) && evt_brk);
    evt_wr  = evt_v && !rep_hit && mode_ok;
    drop    = evt_wr && buf_full && !rd_event;
    ovf_d   = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lm_valid_q <= 1'b0;
      lm_key_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lm_valid_q <= lm_valid_d;
      lm_key_q   <= lm_key_d;
      ovf_q      <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  key_event_fifo #(.B(EVT_W), .W(W_SIZE)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd_event),
    .wr     (evt_wr),
    .w_data ({evt_ext, evt_brk, evt_code}),
    .r_data (event_data),
    .empty  (buf_empty),
    .full   (buf_full)
  );

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Four decoder variants (break-only, make-only, both, both without repeat
// suppression) share one randomized byte stream and are scored against a model.
module tb_ps2_key_event_decoder;

  localparam int NI = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rd_event = 1'b0;
  logic clr_ovf = 1'b0;

  logic [NI-1:0][9:0] ev;
  logic [NI-1:0] emp, ful, ovf;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ps2_key_event_decoder #(
      .W_SIZE(2), .MODE((g < 2) ? g : 2), .NO_REPEAT((g == 3) ? 0 : 1)
    ) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .rd_event(rd_event), .clr_ovf(clr_ovf), .event_data(ev[g]),
      .buf_empty(emp[g]), .buf_full(ful[g]), .overflow(ovf[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_mode [NI] = '{0, 1, 2, 2};
  bit         m_nr   [NI] = '{1, 1, 1, 0};
  logic [9:0] m_list [NI][DEPTH];
  int         m_cnt  [NI];
  bit         m_ovf  [NI];
  bit         m_lmv  [NI];
  logic [8:0] m_lmk  [NI];
  logic [7:0] seq [$];

  function automatic bit discard_byte(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  task automatic model_reset();
    seq.delete();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; m_lmv[i] = 0; m_lmk[i] = '0;
    end
  endtask

  // Decode by looking at the whole pending byte sequence at once
  task automatic decode(input logic [7:0] b, output bit v, output logic [9:0] e);
    int k;
    v = 0; e = '0;
    seq.push_back(b);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) begin v = 1; e = {2'b10, 8'hE1}; seq.delete(); end
    end else if (seq.size() == 1 && discard_byte(seq[0])) begin
      seq.delete();
    end else begin
      k = 0;
      while (k < seq.size() && seq[k] == 8'hE0) k++;
      if (k < seq.size()) begin
        if (seq[k] == 8'hF0) begin
          if (seq.size() == k + 2) begin
            v = 1; e = {k > 0, 1'b1, seq[k+1]}; seq.delete();
          end
        end else begin
          v = 1; e = {k > 0, 1'b0, seq[k]}; seq.delete();
        end
      end
    end
  endtask

  task automatic model_step(input bit tick, input logic [7:0] data, input bit rd, input bit clr);
    bit v, wr, was_full, dropped;
    logic [9:0] e;
    v = 0; e = '0;
    if (tick) decode(data, v, e);
    for (int i = 0; i < NI; i++) begin
      wr = v;
      if (v && m_nr[i]) begin
        if (!e[8]) begin
          if (m_lmv[i] && m_lmk[i] == {e[9], e[7:0]}) wr = 0;
          else begin m_lmv[i] = 1; m_lmk[i] = {e[9], e[7:0]}; end
        end else if (m_lmk[i] == {e[9], e[7:0]}) m_lmv[i] = 0;
      end
      if (m_mode[i] == 0 && !e[8]) wr = 0;
      if (m_mode[i] == 1 && e[8]) wr = 0;
      was_full = (m_cnt[i] == DEPTH);
      dropped = 0;
      if (rd && m_cnt[i] > 0) begin
        for (int j = 0; j < DEPTH - 1; j++) m_list[i][j] = m_list[i][j+1];
        m_cnt[i]--;
      end
      if (wr) begin
        if (was_full && !rd) begin dropped = 1; m_ovf[i] = 1; end
        else begin m_list[i][m_cnt[i]] = e; m_cnt[i]++; end
      end
      if (clr && !dropped) m_ovf[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("empty%0d", i), {9'd0, emp[i]}, {9'd0, m_cnt[i] == 0});
      chk($sformatf("full%0d", i), {9'd0, ful[i]}, {9'd0, m_cnt[i] == DEPTH});
      chk($sformatf("ovf%0d", i), {9'd0, ovf[i]}, {9'd0, m_ovf[i]});
      if (m_cnt[i] > 0) chk($sformatf("head%0d", i), ev[i], m_list[i][0]);
    end
  endtask

  task automatic cyc(input bit tick, input logic [7:0] data, input bit rd, input bit clr);
    @(negedge clk);
    rx_done_tick = tick; rx_data = data; rd_event = rd; clr_ovf = clr;
    model_step(tick, data, rd, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) pop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_done_tick = 0; rd_event = 0; clr_ovf = 0;
    model_reset();
    #2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_data%0d", i), ev[i], 10'h000);
      chk($sformatf("rst_empty%0d", i), {9'd0, emp[i]}, 10'd1);
      chk($sformatf("rst_full%0d", i), {9'd0, ful[i]}, 10'd0);
      chk($sformatf("rst_ovf%0d", i), {9'd0, ovf[i]}, 10'd0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 11))
      0, 1: return 8'hE0;
      2, 3: return 8'hF0;
      4:    return 8'hE1;
      5:    return 8'hAA;
      6, 7: return 8'h1C;
      8:    return 8'h75;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    model_reset();
    do_reset();

    // make then break, both modes
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("t1_head", ev[2], 10'h01C);
    pop();
    chk("t1_pop1", ev[2], 10'h11C);
    pop();
    chk("t1_empty", {9'd0, emp[2]}, 10'd1);

    // extended make/break, break-only instance sees one event
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("t2_head", ev[0], 10'h375);
    pop();
    chk("t2_empty", {9'd0, emp[0]}, 10'd1);
    drain();

    // typematic repeat suppression
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    chk("t3_head", ev[1], 10'h01C);
    pop();
    chk("t3_second", ev[1], 10'h01C);
    pop();
    chk("t3_empty", {9'd0, emp[1]}, 10'd1);
    drain();

    // pause sequence yields one event, AA nothing
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("t4_head", ev[2], 10'h2E1);
    pop();
    send(8'hAA);
    chk("t4_aa_empty", {9'd0, emp[2]}, 10'd1);

    // fill, overflow, simultaneous pop+push, clear
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i));
    chk("t5_full", {9'd0, ful[2]}, 10'd1);
    chk("t5_ovf", {9'd0, ovf[2]}, 10'd1);
    cyc(1'b1, 8'h16, 1'b1, 1'b0);
    chk("t5_rw_ovf", {9'd0, ovf[2]}, 10'd1);
    chk("t5_rw_full", {9'd0, ful[2]}, 10'd1);
    chk("t5_rw_head", ev[2], 10'h012);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_clr", {9'd0, ovf[2]}, 10'd0);
    drain();

    // reset aborts a pending break
    send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("t6_head", ev[2], 10'h01C);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 7, rand_byte(), $urandom_range(0, 9) < 3,
               $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
